// File: rtl/logic_op_pkg.sv
// Shared opcode constants and FSM state encoding for the bit-serial logic unit.
package logic_op_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/bit_logic_cell.sv
// One-bit logic gate cell: evaluates AND/OR/XOR/XNOR of a and b selected by op.
module bit_logic_cell
  import logic_op_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [1:0] op,
  output logic       y
);

  logic y_and;
  logic y_or;
  logic y_xor;
  logic y_xnor;

  assign y_and  = a & b;
  assign y_or   = a | b;
  assign y_xor  = a ^ b;
  assign y_xnor = ~(a ^ b);

  // 4:1 output mux selecting the requested gate
  always_comb begin
    y = y_and;
    case (op)
      OP_AND:  y = y_and;
      OP_OR:   y = y_or;
      OP_XOR:  y = y_xor;
      OP_XNOR: y = y_xnor;
      default: y = y_and;
    endcase
  end

endmodule

// File: rtl/logic_unit_sequencer.sv
// Round-robin arbiter plus bit-serial sequencer sharing one bit_logic_cell
// between two requesters; results return LSB-first assembled on rsp_y.
module logic_unit_sequencer
  import logic_op_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_id,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic             rr_ptr;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic             id_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_next;
  logic             grant0;
  logic             grant1;
  logic             cell_y;

  bit_logic_cell u_cell (
    .a  (a_q[cnt]),
    .b  (b_q[cnt]),
    .op (op_q),
    .y  (cell_y)
  );

  // Round-robin grant; readiness only offered in IDLE and outside reset
  always_comb begin
    grant0     = req0_valid & (~req1_valid | ~rr_ptr);
    grant1     = req1_valid & (~req0_valid |  rr_ptr);
    req0_ready = rst_n & (state == ST_IDLE) & grant0;
    req1_ready = rst_n & (state == ST_IDLE) & grant1;
  end

  // Shift-right with the new cell bit entering at the MSB; loop form keeps WIDTH=1 legal
  always_comb begin
    res_next = '0;
    res_next[WIDTH-1] = cell_y;
    for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
      res_next[i] = res_q[i+1];
    end
  end

  assign busy = (state != ST_IDLE);

  // Sequencer FSM with registered response outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_AND;
      id_q      <= 1'b0;
      cnt       <= '0;
      res_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_id    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant0) begin
            a_q    <= req0_a;
            b_q    <= req0_b;
            op_q   <= req0_op;
            id_q   <= 1'b0;
            rr_ptr <= 1'b1;
            cnt    <= '0;
            res_q  <= '0;
            state  <= ST_RUN;
          end else if (grant1) begin
            a_q    <= req1_a;
            b_q    <= req1_b;
            op_q   <= req1_op;
            id_q   <= 1'b1;
            rr_ptr <= 1'b0;
            cnt    <= '0;
            res_q  <= '0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_q <= res_next;
          if (cnt == CNT_LAST) begin
            rsp_y     <= res_next;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_sequencer.sv
// Directed bench for logic_unit_sequencer: WIDTH=8 main instance plus WIDTH=4 and WIDTH=1 builds.
module tb_logic_unit_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;

  // WIDTH=8 instance
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;
  logic       rsp_valid, rsp_ready, rsp_id, busy;
  logic [7:0] rsp_y;

  // WIDTH=4 instance
  logic       n4_req0_valid, n4_req0_ready, n4_req1_valid, n4_req1_ready;
  logic [3:0] n4_req0_a, n4_req0_b, n4_req1_a, n4_req1_b;
  logic [1:0] n4_req0_op, n4_req1_op;
  logic       n4_rsp_valid, n4_rsp_ready, n4_rsp_id, n4_busy;
  logic [3:0] n4_rsp_y;

  // WIDTH=1 instance
  logic       n1_req0_valid, n1_req0_ready, n1_req1_valid, n1_req1_ready;
  logic [0:0] n1_req0_a, n1_req0_b, n1_req1_a, n1_req1_b;
  logic [1:0] n1_req0_op, n1_req1_op;
  logic       n1_rsp_valid, n1_rsp_ready, n1_rsp_id, n1_busy;
  logic [0:0] n1_rsp_y;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  logic_unit_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_id(rsp_id), .busy(busy)
  );

  logic_unit_sequencer #(.WIDTH(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(n4_req0_valid), .req0_ready(n4_req0_ready), .req0_a(n4_req0_a), .req0_b(n4_req0_b), .req0_op(n4_req0_op),
    .req1_valid(n4_req1_valid), .req1_ready(n4_req1_ready), .req1_a(n4_req1_a), .req1_b(n4_req1_b), .req1_op(n4_req1_op),
    .rsp_valid(n4_rsp_valid), .rsp_ready(n4_rsp_ready), .rsp_y(n4_rsp_y), .rsp_id(n4_rsp_id), .busy(n4_busy)
  );

  logic_unit_sequencer #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(n1_req0_valid), .req0_ready(n1_req0_ready), .req0_a(n1_req0_a), .req0_b(n1_req0_b), .req0_op(n1_req0_op),
    .req1_valid(n1_req1_valid), .req1_ready(n1_req1_ready), .req1_a(n1_req1_a), .req1_b(n1_req1_b), .req1_op(n1_req1_op),
    .rsp_valid(n1_rsp_valid), .rsp_ready(n1_rsp_ready), .rsp_y(n1_rsp_y), .rsp_id(n1_rsp_id), .busy(n1_busy)
  );

  // The two readies of the main instance must never be high together
  always @(negedge clk) begin
    vectors++;
    if (req0_ready && req1_ready) begin
      miscompares++;
      $display("FAIL ready_exclusive: req0_ready=%b req1_ready=%b required not both 1", req0_ready, req1_ready);
    end
  end

  // Bounded wait for the main instance response; cyc=-1 if it never arrives
  task automatic wait_rsp(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'hFF; req0_op = 2'b00;
    req1_valid = 1'b1; req1_a = 8'h00; req1_b = 8'h00; req1_op = 2'b00;
    rsp_ready = 1'b1;
    n4_req0_valid = 0; n4_req0_a = '0; n4_req0_b = '0; n4_req0_op = '0;
    n4_req1_valid = 0; n4_req1_a = '0; n4_req1_b = '0; n4_req1_op = '0; n4_rsp_ready = 1'b1;
    n1_req0_valid = 0; n1_req0_a = '0; n1_req0_b = '0; n1_req0_op = '0;
    n1_req1_valid = 0; n1_req1_a = '0; n1_req1_b = '0; n1_req1_op = '0; n1_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_y !== 8'h00 || rsp_id !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b y=%h id=%b busy=%b required 0 00 0 0", rsp_valid, rsp_y, rsp_id, busy);
    end
    vectors++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: ready0=%b ready1=%b required 0 0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_req0_and();
    req0_a = 8'hF0; req0_b = 8'h3C; req0_op = 2'b00; req0_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    vectors++;
    if (req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL and_ready: req0_ready=%b required 1", req0_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== (k == 8)) begin
        miscompares++;
        $display("FAIL and_latency: cycle %0d rsp_valid=%b required %b", k, rsp_valid, (k == 8));
      end
    end
    vectors++;
    if (rsp_y !== 8'h30 || rsp_id !== 1'b0) begin
      miscompares++;
      $display("FAIL and_result: y=%h id=%b required 30 0", rsp_y, rsp_id);
    end
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL and_complete: valid=%b busy=%b required 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_req1_xnor();
    int cyc;
    req1_a = 8'hA5; req1_b = 8'h0F; req1_op = 2'b11; req1_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    // Port contents change after acceptance must not disturb the operation
    req1_valid = 1'b0; req1_a = 8'h3C; req1_b = 8'hC3; req1_op = 2'b00;
    wait_rsp(20, cyc);
    vectors++;
    if (cyc != 8 || rsp_y !== 8'h55 || rsp_id !== 1'b1) begin
      miscompares++;
      $display("FAIL xnor_result: cycles=%0d y=%h id=%b required 8 55 1", cyc, rsp_y, rsp_id);
    end
    @(negedge clk);
  endtask

  task automatic test_alternation();
    int cyc;
    logic exp_id;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req0_a = 8'h01; req0_b = 8'h02; req0_op = 2'b01;
    req1_a = 8'hFF; req1_b = 8'h0F; req1_op = 2'b10;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp_id = t[0];
      wait_rsp(20, cyc);
      vectors++;
      if (cyc < 0 || rsp_id !== exp_id || rsp_y !== (exp_id ? 8'hF0 : 8'h03)) begin
        miscompares++;
        $display("FAIL alternate_%0d: cycles=%0d id=%b y=%h required id %b y %h",
                 t, cyc, rsp_id, rsp_y, exp_id, (exp_id ? 8'hF0 : 8'h03));
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int cyc;
    req0_a = 8'hF0; req0_b = 8'h3C; req0_op = 2'b00; req0_valid = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0;
    wait_rsp(20, cyc);
    vectors++;
    if (cyc != 8) begin
      miscompares++;
      $display("FAIL bp_arrive: cycles=%0d required 8", cyc);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_y !== 8'h30 || rsp_id !== 1'b0 || busy !== 1'b1 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: valid=%b y=%h id=%b busy=%b rdy=%b%b required 1 30 0 1 00",
                 k, rsp_valid, rsp_y, rsp_id, busy, req0_ready, req1_ready);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_y !== 8'h30) begin
      miscompares++;
      $display("FAIL bp_release: valid=%b busy=%b y=%h required 0 0 30", rsp_valid, busy, rsp_y);
    end
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    // Abort a req1 operation at cnt=3
    req1_a = 8'h55; req1_b = 8'hAA; req1_op = 2'b01; req1_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_y !== 8'h00 || rsp_id !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_outputs: valid=%b busy=%b y=%h id=%b required 0 0 00 0", rsp_valid, busy, rsp_y, rsp_id);
    end
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL abort_no_rsp: rsp_valid rose=1 required 0");
    end
    // Abort a req0 operation in RESP so the pointer would otherwise favour req1
    req0_a = 8'h0F; req0_b = 8'hFF; req0_op = 2'b00; req0_valid = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_rr_reset: ready0=%b ready1=%b valid=%b required 1 0 0", req0_ready, req1_ready, rsp_valid);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_narrow_widths();
    n4_req0_a = 4'h9; n4_req0_b = 4'h3; n4_req0_op = 2'b10; n4_req0_valid = 1'b1;
    n1_req0_a = 1'b1; n1_req0_b = 1'b1; n1_req0_op = 2'b11; n1_req0_valid = 1'b1;
    @(negedge clk);
    n4_req0_valid = 1'b0; n1_req0_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      vectors++;
      if (n4_rsp_valid !== (k == 4)) begin
        miscompares++;
        $display("FAIL w4_latency: cycle %0d rsp_valid=%b required %b", k, n4_rsp_valid, (k == 4));
      end
      if (k == 1) begin
        vectors++;
        if (n1_rsp_valid !== 1'b1 || n1_rsp_y !== 1'b1 || n1_rsp_id !== 1'b0) begin
          miscompares++;
          $display("FAIL w1_result: valid=%b y=%b id=%b required 1 1 0", n1_rsp_valid, n1_rsp_y, n1_rsp_id);
        end
      end
    end
    vectors++;
    if (n4_rsp_y !== 4'hA || n4_rsp_id !== 1'b0) begin
      miscompares++;
      $display("FAIL w4_result: y=%h id=%b required a 0", n4_rsp_y, n4_rsp_id);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_req0_and();
    test_req1_xnor();
    test_alternation();
    test_backpressure();
    test_reset_mid_op();
    test_narrow_widths();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
